cfa_demosaic: RTL and testbench
===============================

Name: cfa_demosaic

Overview:
- Parametrised successor to the first-generation Bayer demosaic.
- Converts a raw Bayer AXI-Stream (one pixel per beat) into packed RGB using a 3x3 window.
- Line storage is internal, so the block needs no external FIFO ports.
- Phase and interpolation mode are runtime-configurable per frame. Sits between the sensor capture stream and the RGB video pipeline.

Parameters:
- C_PIXEL_WIDTH, 8, bits per raw sample and per output colour component.
- C_MAX_WIDTH, 2048, maximum line length in pixels; sets line-buffer depth.
- C_ADDR_WIDTH, 11, column counter width; must satisfy 2^C_ADDR_WIDTH >= C_MAX_WIDTH.

Ports:
- clk  in  1  pipeline clock.
- resetn  in  1  reset; asynchronous, active-low.
- cfg_phase  in  2  Bayer phase of the top-left pixel: 0=R, 1=Gr, 2=Gb, 3=B.
- cfg_mode  in  2  0=bilinear, 1=edge-directed green, 2=bypass (raw replicated to R,G,B), 3=reserved (treated as 0).
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tdata  in  C_PIXEL_WIDTH  raw sample.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- s_axis_tready  out  1  input ready.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tdata  out  3*C_PIXEL_WIDTH  {R,G,B}.
- m_axis_tuser  out  1  first pixel of output frame.
- m_axis_tlast  out  1  last pixel of output line.
- m_axis_tready  in  1  output ready.
- err_width  out  1  sticky: a line length differed from the first line of the frame; cleared on the next tuser.

Behaviour:
- Reset values: all outputs 0. s_axis_tready is 0 only while resetn is low.
- Reset mid-frame discards all state. The block waits for tuser; beats before tuser are accepted and dropped.
- Global advance enable: en = ~m_axis_tvalid | m_axis_tready. s_axis_tready = en. Every pipeline register advances only on en.
- cfg_phase and cfg_mode are sampled when a tuser beat is accepted and held for the whole frame.
- Counters: col (C_ADDR_WIDTH) and row (16 bits).
  - tuser resets col=0, row=0; tuser overrides any in-progress line.
  - An accepted tlast beat sets col=0 and row+1. Otherwise an accepted beat increments col.
  - col saturates at C_MAX_WIDTH-1. Beats beyond that are accepted; the line buffers are not written.
- Width check: the width of the first line is latched. Any later line whose tlast arrives at a different col sets err_width. Output geometry always follows the first-line width.
- Line buffers: two C_MAX_WIDTH x C_PIXEL_WIDTH simple dual-port RAMs, 1-cycle read, read-before-write at the same address. A 3x3 shift window is built from {lb1, lb0, input}.
- Output crop: the output frame is (W-2)x(H-2).
  - Centre (r,c) is emitted when input (r+1,c+1) is accepted, with r,c >= 1.
  - Latency: 2 en-cycles from accepting that beat to m_axis_tvalid.
  - m_axis_tuser is set on centre (1,1). m_axis_tlast is set on centre (r,W-2).
- Centre phase: phase = cfg_phase XOR {r[0], c[0]}.
- Bilinear interpolation:
  - At R/B sites, G = (N+S+E+W)>>2 and the opposite colour = (NW+NE+SW+SE)>>2.
  - At G sites, horizontal neighbours supply the row colour: R at Gr, B at Gb. Vertical neighbours supply the other colour; each is (a+b)>>1.
  - Sums use width +2 bits and truncate (no rounding).
- Edge-directed green (mode 1, R/B sites only): dh = |W-E|, dv = |N-S|.
  - dv<dh gives G=(N+S)>>1.
  - dh<dv gives G=(W+E)>>1.
  - equal gives the bilinear value.
- Bypass (mode 2): R=G=B=centre. Crop and latency are unchanged.
- A frame shorter than 3 rows or 3 columns produces no output and raises no error.

Decomposition:
- Package cfa_pkg holds the phase constants (PH_R, PH_GR, PH_GB, PH_B) and mode constants (MODE_BILINEAR, MODE_EDGE, MODE_BYPASS).
- Sub-module cfa_linebuf: parametrised single line RAM with a registered read and an enable.
- Top level holds the counters, window, interpolation and handshake.

Test Plan:
- 6x4 frame, all samples = 100, mode 0, phase 0, tready=1 -> 8 beats, each {100,100,100}; tuser on beat 0; tlast on beats 3 and 7.
- 5x5 ramp (value = 10*row + col), phase 0, mode 0 -> centre (2,2) is an R site: R=22, G=22, B=22. Centre (1,2) is Gb: G=12, R=12, B=12.
- Vertical edge (cols 0-1 = 0, cols 2-4 = 200), mode 1, centre (2,2) at an R site -> G=200 (vertical average). Mode 0 on the same image -> G=150.
- Random m_axis_tready at 30% duty -> output stream identical to the tready=1 run; no beat lost or duplicated; m_axis_tdata stable while tvalid && !tready.
- Second line tlast one pixel early -> err_width=1 and held; next tuser clears it; output geometry of the following frame is correct.
- Assert resetn low mid-line, release, send a fresh 4x4 frame -> exactly 4 outputs with correct tuser/tlast; no data from the aborted frame.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared constants for the Bayer CFA demosaic.
//   PH_*   : Bayer phase of a pixel site, encoded as {row parity, column parity}
//            relative to an R site.
//   MODE_* : interpolation mode selected per frame.
package cfa_pkg;

  localparam logic [1:0] PH_R  = 2'd0;
  localparam logic [1:0] PH_GR = 2'd1;
  localparam logic [1:0] PH_GB = 2'd2;
  localparam logic [1:0] PH_B  = 2'd3;

  localparam logic [1:0] MODE_BILINEAR = 2'd0;
  localparam logic [1:0] MODE_EDGE     = 2'd1;
  localparam logic [1:0] MODE_BYPASS   = 2'd2;

endpackage

// File: rtl/cfa_linebuf.sv
// Single line store: simple dual-port RAM, registered read with enable.
// A read and a write to the same address in one cycle return the old data.
//   clk      : clock
//   i_rd_en  : capture r_mem[i_raddr] into o_rdata
//   i_raddr  : read address
//   o_rdata  : registered read data
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
module cfa_linebuf #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_MAX_WIDTH   = 2048,
  parameter int C_ADDR_WIDTH  = 11
) (
  input  logic                     clk,
  input  logic                     i_rd_en,
  input  logic [C_ADDR_WIDTH-1:0]  i_raddr,
  output logic [C_PIXEL_WIDTH-1:0] o_rdata,
  input  logic                     i_we,
  input  logic [C_ADDR_WIDTH-1:0]  i_waddr,
  input  logic [C_PIXEL_WIDTH-1:0] i_wdata
);

  logic [C_PIXEL_WIDTH-1:0] r_mem [C_MAX_WIDTH];
  logic [C_PIXEL_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_rd_en) r_rdata <= r_mem[i_raddr];
    if (i_we)    r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cfa_demosaic.sv
// Bayer CFA demosaic: raw AXI-Stream (one pixel/beat) to packed {R,G,B} via a
// 3x3 window built from two internal line stores and the live input.
// Output frame is cropped by one pixel on every side.
//   clk, resetn          : clock, asynchronous active-low reset
//   cfg_phase, cfg_mode  : Bayer phase of pixel (0,0) and interpolation mode,
//                          captured with the start-of-frame beat
//   s_axis_*             : raw input stream (tuser = SOF, tlast = EOL)
//   m_axis_*             : RGB output stream (tuser = first pixel, tlast = EOL)
//   err_width            : sticky line-length mismatch, cleared by next SOF
module cfa_demosaic
  import cfa_pkg::*;
#(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_MAX_WIDTH   = 2048,
  parameter int C_ADDR_WIDTH  = 11
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [1:0]                 cfg_phase,
  input  logic [1:0]                 cfg_mode,
  input  logic                       s_axis_tvalid,
  input  logic [C_PIXEL_WIDTH-1:0]   s_axis_tdata,
  input  logic                       s_axis_tuser,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [3*C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready,
  output logic                       err_width
);

  localparam int PW = C_PIXEL_WIDTH;
  localparam int AW = C_ADDR_WIDTH;
  localparam logic [AW-1:0] COL_MAX = AW'(C_MAX_WIDTH - 1);

  function automatic logic [PW-1:0] avg2(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PW:1];
  endfunction

  function automatic logic [PW-1:0] avg4(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                         input logic [PW-1:0] c, input logic [PW-1:0] d);
    logic [PW+1:0] s;
    s = {2'b0, a} + {2'b0, b} + {2'b0, c} + {2'b0, d};
    return s[PW+1:2];
  endfunction

  function automatic logic [PW-1:0] absdiff(input logic [PW-1:0] a, input logic [PW-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  logic            w_en, w_acc;
  logic            r_m_tvalid, r_m_tuser, r_m_tlast, r_err;
  logic [3*PW-1:0] r_m_tdata;

  assign w_en          = ~r_m_tvalid | m_axis_tready;
  assign s_axis_tready = w_en & resetn;
  assign w_acc         = s_axis_tvalid & s_axis_tready;

  // Frame/line bookkeeping. A tuser beat is pixel (0,0) regardless of the
  // counter state, so the current-beat view substitutes SOF values.
  logic            r_infrm, r_sat, r_wvld;
  logic [AW-1:0]   r_col, r_last_col;
  logic [15:0]     r_row;
  logic [1:0]      r_phase, r_mode;

  logic            w_infrm, w_sat, w_wvld, w_we, w_emit;
  logic [AW-1:0]   w_col;
  logic [15:0]     w_row;
  logic [1:0]      w_phase, w_mode, w_cfg_mode, w_cph;

  assign w_cfg_mode = (cfg_mode == 2'd3) ? MODE_BILINEAR : cfg_mode;
  assign w_infrm    = s_axis_tuser | r_infrm;
  assign w_col      = s_axis_tuser ? '0 : r_col;
  assign w_row      = s_axis_tuser ? '0 : r_row;
  assign w_sat      = ~s_axis_tuser & r_sat;
  assign w_wvld     = ~s_axis_tuser & r_wvld;
  assign w_phase    = s_axis_tuser ? cfg_phase : r_phase;
  assign w_mode     = s_axis_tuser ? w_cfg_mode : r_mode;
  assign w_we       = w_acc & w_infrm & ~w_sat;
  // Centre is one row up and one column left of the incoming pixel.
  assign w_emit     = w_we & w_wvld & (w_row >= 16'd2) & (w_col >= AW'(2)) &
                      (w_col <= r_last_col);
  assign w_cph      = w_phase ^ {~w_row[0], ~w_col[0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_infrm    <= 1'b0;
      r_sat      <= 1'b0;
      r_wvld     <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_last_col <= '0;
      r_phase    <= '0;
      r_mode     <= '0;
      r_err      <= 1'b0;
    end else if (w_acc && w_infrm) begin
      r_infrm <= 1'b1;
      r_phase <= w_phase;
      r_mode  <= w_mode;
      if (s_axis_tlast) begin
        r_col <= '0;
        r_row <= w_row + 16'd1;
        r_sat <= 1'b0;
      end else begin
        r_row <= w_row;
        r_col <= (w_col == COL_MAX) ? w_col : w_col + AW'(1);
        r_sat <= (w_col == COL_MAX);
      end
      // First line of the frame defines the geometry; later lines are checked.
      r_wvld     <= w_wvld | s_axis_tlast;
      r_last_col <= (s_axis_tlast && !w_wvld) ? w_col : r_last_col;
      r_err      <= (r_err & ~s_axis_tuser) |
                    (s_axis_tlast & w_wvld & (w_col != r_last_col));
    end
  end

  // Stage p0: line-store reads and registered input pixel
  logic            r_acc_p0, r_we_p0, r_emit_p0, r_sof_p0, r_eol_p0;
  logic [PW-1:0]   r_pix_p0;
  logic [AW-1:0]   r_col_p0;
  logic [1:0]      r_ph_p0, r_mode_p0;
  logic [PW-1:0]   w_lb0, w_lb1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_acc_p0  <= 1'b0;
      r_we_p0   <= 1'b0;
      r_emit_p0 <= 1'b0;
      r_sof_p0  <= 1'b0;
      r_eol_p0  <= 1'b0;
    end else if (w_en) begin
      r_acc_p0  <= w_acc;
      r_we_p0   <= w_we;
      r_emit_p0 <= w_emit;
      r_sof_p0  <= w_emit & (w_row == 16'd2) & (w_col == AW'(2));
      r_eol_p0  <= w_emit & (w_col == r_last_col);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_pix_p0  <= s_axis_tdata;
      r_col_p0  <= w_col;
      r_ph_p0   <= w_cph;
      r_mode_p0 <= w_mode;
    end
  end

  cfa_linebuf #(.C_PIXEL_WIDTH(PW), .C_MAX_WIDTH(C_MAX_WIDTH), .C_ADDR_WIDTH(AW)) u_lb0 (
    .clk(clk), .i_rd_en(w_acc), .i_raddr(w_col), .o_rdata(w_lb0),
    .i_we(w_we), .i_waddr(w_col), .i_wdata(s_axis_tdata)
  );

  // lb1 is fed from lb0's read-out one stage later, so it always holds row-2.
  cfa_linebuf #(.C_PIXEL_WIDTH(PW), .C_MAX_WIDTH(C_MAX_WIDTH), .C_ADDR_WIDTH(AW)) u_lb1 (
    .clk(clk), .i_rd_en(w_acc), .i_raddr(w_col), .o_rdata(w_lb1),
    .i_we(w_en & r_we_p0), .i_waddr(r_col_p0), .i_wdata(w_lb0)
  );

  // Stage p1: 3x3 window (row 0 = oldest line, column 2 = newest pixel)
  logic [PW-1:0]   r_win_p1 [3][3];
  logic            r_vld_p1, r_sof_p1, r_eol_p1;
  logic [1:0]      r_ph_p1, r_mode_p1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vld_p1 <= 1'b0;
      r_sof_p1 <= 1'b0;
      r_eol_p1 <= 1'b0;
    end else if (w_en) begin
      r_vld_p1 <= r_emit_p0;
      r_sof_p1 <= r_sof_p0;
      r_eol_p1 <= r_eol_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_en && r_acc_p0) begin
      for (int i = 0; i < 3; i++) begin
        r_win_p1[i][0] <= r_win_p1[i][1];
        r_win_p1[i][1] <= r_win_p1[i][2];
      end
      r_win_p1[0][2] <= w_lb1;
      r_win_p1[1][2] <= w_lb0;
      r_win_p1[2][2] <= r_pix_p0;
      r_ph_p1        <= r_ph_p0;
      r_mode_p1      <= r_mode_p0;
    end
  end

  logic [PW-1:0]   w_c, w_n, w_s, w_w, w_e, w_g4, w_d4, w_h2, w_v2, w_dh, w_dv, w_g_rb;
  logic [3*PW-1:0] w_rgb;

  assign w_c  = r_win_p1[1][1];
  assign w_n  = r_win_p1[0][1];
  assign w_s  = r_win_p1[2][1];
  assign w_w  = r_win_p1[1][0];
  assign w_e  = r_win_p1[1][2];
  assign w_g4 = avg4(w_n, w_s, w_w, w_e);
  assign w_d4 = avg4(r_win_p1[0][0], r_win_p1[0][2], r_win_p1[2][0], r_win_p1[2][2]);
  assign w_h2 = avg2(w_w, w_e);
  assign w_v2 = avg2(w_n, w_s);
  assign w_dh = absdiff(w_w, w_e);
  assign w_dv = absdiff(w_n, w_s);

  always_comb begin
    w_g_rb = w_g4;
    if (r_mode_p1 == MODE_EDGE) begin
      if (w_dv < w_dh)      w_g_rb = w_v2;
      else if (w_dh < w_dv) w_g_rb = w_h2;
    end
    w_rgb = {w_c, w_c, w_c};
    if (r_mode_p1 != MODE_BYPASS) begin
      case (r_ph_p1)
        PH_R:    w_rgb = {w_c,  w_g_rb, w_d4};
        PH_GR:   w_rgb = {w_h2, w_c,    w_v2};
        PH_GB:   w_rgb = {w_v2, w_c,    w_h2};
        default: w_rgb = {w_d4, w_g_rb, w_c};
      endcase
    end
  end

  // Stage p2: output register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tdata  <= '0;
    end else if (w_en) begin
      r_m_tvalid <= r_vld_p1;
      r_m_tuser  <= r_sof_p1;
      r_m_tlast  <= r_eol_p1;
      if (r_vld_p1) r_m_tdata <= w_rgb;
    end
  end

  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tlast  = r_m_tlast;
  assign err_width     = r_err;

endmodule

// File: tb/tb_cfa_demosaic.sv
module tb_cfa_demosaic;

  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  cfg_phase, cfg_mode;
  logic        s_tvalid, s_tuser, s_tlast, s_tready;
  logic [7:0]  s_tdata;
  logic        m_tvalid, m_tuser, m_tlast, m_tready;
  logic [23:0] m_tdata;
  logic        err_width;

  always #5 clk = ~clk;

  cfa_demosaic dut (
    .clk(clk), .resetn(resetn), .cfg_phase(cfg_phase), .cfg_mode(cfg_mode),
    .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready), .err_width(err_width)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  img [0:7][0:7];
  logic [25:0] q [$];
  bit          rnd_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: collects handshaken beats and checks data holds while stalled.
  always @(negedge clk) begin
    if (prev_stall) chk("hold_tdata", 32'(m_tdata), 32'(prev_data));
    if (m_tvalid && m_tready) q.push_back({m_tuser, m_tlast, m_tdata});
    prev_stall = m_tvalid && !m_tready && resetn;
    prev_data  = m_tdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    m_tready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  endtask

  task automatic send_pix(input logic [7:0] d, input logic u, input logic l);
    bit hs;
    int n;
    s_tvalid = 1'b1; s_tdata = d; s_tuser = u; s_tlast = l;
    hs = 1'b0; n = 0;
    while (!hs && n < 2000) begin
      #1;
      hs = s_tready;
      tick();
      n++;
    end
    s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    if (!hs) chk("accept_timeout", 32'(hs), 32'd1);
  endtask

  // early >= 0: that row ends one pixel short. nmax: stop after nmax beats.
  task automatic send_frame(input int w, input int h, input int early, input int nmax);
    int sent;
    sent = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (sent >= nmax) return;
        if (r == early && c == w - 1) break;
        send_pix(img[r][c], (r == 0 && c == 0), (c == w - 1) || (r == early && c == w - 2));
        sent++;
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input logic [1:0] ph,
                           input logic [1:0] md, input int ndrain);
    cfg_phase = ph; cfg_mode = md;
    q.delete();
    send_frame(w, h, -1, 1000);
    repeat (ndrain) tick();
  endtask

  task automatic chk_beat(input string tag, input int idx, input bit u, input bit l,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    if (idx < q.size()) chk(tag, 32'(q[idx]), 32'({u, l, r, g, b}));
    else chk({tag, "_missing"}, 32'(q.size()), 32'(idx + 1));
  endtask

  task automatic fill_flat(input logic [7:0] v);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = v;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = 8'(10 * r + c);
  endtask

  task automatic fill_vedge();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (c >= 2) ? 8'd201 : 8'd0;
  endtask

  task automatic fill_hedge();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) img[r][c] = (r >= 2) ? 8'd201 : 8'd0;
  endtask

  task automatic chk_ramp5(input string tag);
    int v;
    chk({tag, "_count"}, 32'(q.size()), 32'd9);
    for (int i = 0; i < 9; i++) begin
      v = 10 * (1 + i / 3) + (1 + i % 3);
      chk_beat(tag, i, (i == 0), (i % 3 == 2), 8'(v), 8'(v), 8'(v));
    end
  endtask

  initial begin
    resetn = 1'b0; cfg_phase = 2'd0; cfg_mode = 2'd0;
    s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    repeat (3) tick();
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tdata",  32'(m_tdata),  32'd0);
    chk("rst_m_tuser",  32'(m_tuser),  32'd0);
    chk("rst_m_tlast",  32'(m_tlast),  32'd0);
    chk("rst_err",      32'(err_width), 32'd0);
    resetn = 1'b1;
    tick();
    chk("s_tready_after_rst", 32'(s_tready), 32'd1);

    // Flat 6x4
    fill_flat(8'd100);
    run_frame(6, 4, 2'd0, 2'd0, 20);
    chk("flat_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk_beat("flat", i, (i == 0), (i == 3 || i == 7), 8'd100, 8'd100, 8'd100);

    // 5x5 ramp: linear image, every site interpolates to its own value
    fill_ramp();
    run_frame(5, 5, 2'd0, 2'd0, 20);
    chk_ramp5("ramp");

    // Vertical edge, edge-directed and bilinear, phase variants, bypass
    fill_vedge();
    run_frame(5, 5, 2'd0, 2'd1, 20);
    chk_beat("vedge_m1_c11", 0, 1'b1, 1'b0, 8'd100, 8'd0,   8'd0);
    chk_beat("vedge_m1_c12", 1, 1'b0, 1'b0, 8'd201, 8'd201, 8'd100);
    chk_beat("vedge_m1_c22", 4, 1'b0, 1'b0, 8'd201, 8'd201, 8'd100);
    run_frame(5, 5, 2'd0, 2'd0, 20);
    chk_beat("vedge_m0_c11", 0, 1'b1, 1'b0, 8'd100, 8'd50,  8'd0);
    chk_beat("vedge_m0_c22", 4, 1'b0, 1'b0, 8'd201, 8'd150, 8'd100);
    run_frame(5, 5, 2'd3, 2'd0, 20);
    chk_beat("vedge_ph3_c11", 0, 1'b1, 1'b0, 8'd0,   8'd50,  8'd100);
    chk_beat("vedge_ph3_c22", 4, 1'b0, 1'b0, 8'd100, 8'd150, 8'd201);
    run_frame(5, 5, 2'd0, 2'd2, 20);
    chk_beat("vedge_byp_c11", 0, 1'b1, 1'b0, 8'd0,   8'd0,   8'd0);
    chk_beat("vedge_byp_c22", 4, 1'b0, 1'b0, 8'd201, 8'd201, 8'd201);
    run_frame(5, 5, 2'd0, 2'd3, 20);
    chk_beat("vedge_m3_c22", 4, 1'b0, 1'b0, 8'd201, 8'd150, 8'd100);
    fill_hedge();
    run_frame(5, 5, 2'd0, 2'd1, 20);
    chk_beat("hedge_m1_c22", 4, 1'b0, 1'b0, 8'd201, 8'd201, 8'd100);

    // Backpressure at 30% ready
    fill_ramp();
    rnd_ready = 1'b1;
    run_frame(5, 5, 2'd0, 2'd0, 200);
    rnd_ready = 1'b0;
    tick();
    chk_ramp5("ramp_bp");

    // Width error: second line one pixel short
    fill_flat(8'd100);
    cfg_phase = 2'd0; cfg_mode = 2'd0;
    send_frame(6, 4, 1, 1000);
    repeat (20) tick();
    chk("err_set", 32'(err_width), 32'd1);
    repeat (20) tick();
    chk("err_held", 32'(err_width), 32'd1);
    run_frame(6, 4, 2'd0, 2'd0, 20);
    chk("err_cleared", 32'(err_width), 32'd0);
    chk("after_err_count", 32'(q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk_beat("after_err", i, (i == 0), (i == 3 || i == 7), 8'd100, 8'd100, 8'd100);

    // Reset mid-line, stray beats before SOF, fresh 4x4
    fill_flat(8'd50);
    send_frame(6, 4, -1, 15);
    resetn = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    q.delete();
    send_pix(8'hEE, 1'b0, 1'b0);
    send_pix(8'hEE, 1'b0, 1'b0);
    send_pix(8'hEE, 1'b0, 1'b1);
    fill_ramp();
    run_frame(4, 4, 2'd0, 2'd0, 20);
    chk("rst4_count", 32'(q.size()), 32'd4);
    chk_beat("rst4_c11", 0, 1'b1, 1'b0, 8'd11, 8'd11, 8'd11);
    chk_beat("rst4_c12", 1, 1'b0, 1'b1, 8'd12, 8'd12, 8'd12);
    chk_beat("rst4_c21", 2, 1'b0, 1'b0, 8'd21, 8'd21, 8'd21);
    chk_beat("rst4_c22", 3, 1'b0, 1'b1, 8'd22, 8'd22, 8'd22);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
